// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control tokens, alignment FSM states and offset helper
package tmds_pkg;
    localparam logic [9:0] CTL_00 = 10'b1101010100;
    localparam logic [9:0] CTL_01 = 10'b0010101011;
    localparam logic [9:0] CTL_10 = 10'b0101010100;
    localparam logic [9:0] CTL_11 = 10'b1010101011;

    typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

    function automatic logic [3:0] next_offset(input logic [3:0] o);
        return (o == 4'd9) ? 4'd0 : o + 4'd1;
    endfunction
endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational decode of one aligned 10-bit TMDS symbol
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] i_sym,
    output logic       o_is_ctl,
    output logic       o_vde,
    output logic [1:0] o_cd,
    output logic [7:0] o_vd
);
    logic [7:0] w_d;

    always_comb begin
        w_d      = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];
        o_vd     = {w_d[7:1] ^ w_d[6:0] ^ {7{~i_sym[8]}}, w_d[0]};
        o_is_ctl = (i_sym == CTL_00) || (i_sym == CTL_01) || (i_sym == CTL_10) || (i_sym == CTL_11);
        o_cd     = (i_sym == CTL_01) ? 2'd1 : (i_sym == CTL_10) ? 2'd2 : (i_sym == CTL_11) ? 2'd3 : 2'd0;
        o_vde    = ~o_is_ctl;
    end
endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: bit-slip symbol alignment on control tokens plus TMDS symbol decode
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT  = 16,
    parameter int SEARCH_WAIT = 4096,
    parameter int LOSS_WAIT   = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] tmds_in,
    output logic [7:0] vd,
    output logic [1:0] cd,
    output logic       vde,
    output logic       locked,
    output logic [3:0] offset,
    output logic [7:0] loss_cnt
);
    localparam int CW = $clog2(LOSS_WAIT) + 1;
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_COUNT - 1);
    localparam logic [CW-1:0] SEARCH_LAST = CW'(SEARCH_WAIT - 1);
    localparam logic [CW-1:0] LOSS_LAST   = CW'(LOSS_WAIT - 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [9:0]      r_w1, r_w2;
    logic [19:0]     w_cat;
    logic [9:0]      w_win;
    logic            w_is_ctl, w_vde, w_enter, w_drop, w_lock_next;
    logic [1:0]      w_cd;
    logic [7:0]      w_vd;

    tmds_symbol_decode u_dec (
        .i_sym    (w_win),
        .o_is_ctl (w_is_ctl),
        .o_vde    (w_vde),
        .o_cd     (w_cd),
        .o_vd     (w_vd)
    );

    // outputs follow the next lock state so the locking token is itself emitted
    always_comb begin
        w_cat       = {r_w1, r_w2};
        w_win       = w_cat[offset +: 10];
        w_enter     = (r_state == CONFIRM) && w_is_ctl && (r_cnt == LOCK_LAST);
        w_drop      = (r_state == LOCKED) && !w_is_ctl && (r_cnt == LOSS_LAST);
        w_lock_next = w_enter || ((r_state == LOCKED) && !w_drop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w1     <= '0;
            r_w2     <= '0;
            r_state  <= SEARCH;
            r_cnt    <= '0;
            offset   <= '0;
            loss_cnt <= '0;
            locked   <= 1'b0;
            vde      <= 1'b0;
            cd       <= '0;
            vd       <= '0;
        end else begin
            r_w1 <= tmds_in;
            r_w2 <= r_w1;
            case (r_state)
                SEARCH: begin
                    if (w_is_ctl) begin
                        r_state <= CONFIRM;
                        r_cnt   <= CW'(1);
                    end else if (r_cnt == SEARCH_LAST) begin
                        offset <= next_offset(offset);
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                CONFIRM: begin
                    if (!w_is_ctl) begin
                        r_state <= SEARCH;
                        offset  <= next_offset(offset);
                        r_cnt   <= '0;
                    end else if (w_enter) begin
                        r_state <= LOCKED;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                LOCKED: begin
                    if (w_is_ctl) begin
                        r_cnt <= '0;
                    end else if (w_drop) begin
                        r_state  <= SEARCH;
                        r_cnt    <= '0;
                        loss_cnt <= (loss_cnt == 8'hFF) ? loss_cnt : loss_cnt + 8'd1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= SEARCH;
                    r_cnt   <= '0;
                end
            endcase
            locked <= w_lock_next;
            vde    <= w_lock_next & w_vde;
            vd     <= (w_lock_next & w_vde) ? w_vd : 8'd0;
            cd     <= !w_lock_next ? 2'd0 : w_is_ctl ? w_cd : cd;
        end
    end
endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: randomized and directed checks against a cycle-level behavioural model
module tb_tmds_decoder;
    localparam int LC = 4;
    localparam int SW = 32;
    localparam int LW = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] tmds_in = '0;
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
    logic       locked;
    logic [3:0] offset;
    logic [7:0] loss_cnt;

    tmds_decoder #(.LOCK_COUNT(LC), .SEARCH_WAIT(SW), .LOSS_WAIT(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .tmds_in  (tmds_in),
        .vd       (vd),
        .cd       (cd),
        .vde      (vde),
        .locked   (locked),
        .offset   (offset),
        .loss_cnt (loss_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [9:0] tok [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    int         m_mode, m_run, m_off, m_loss;
    logic [9:0] m_w1, m_w2;
    logic       e_lock, e_vde;
    logic [1:0] e_cd;
    logic [7:0] e_vd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int tok_idx(input logic [9:0] w);
        for (int i = 0; i < 4; i++) if (w == tok[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] s);
        logic [7:0] d, v;
        d = s[9] ? ~s[7:0] : s[7:0];
        v[0] = d[0];
        for (int i = 1; i < 8; i++) v[i] = s[8] ? (d[i] ^ d[i-1]) : !(d[i] ^ d[i-1]);
        return v;
    endfunction

    function automatic logic [9:0] nontok();
        logic [9:0] w;
        w = 10'($urandom_range(0, 1023));
        if (tok_idx(w) >= 0) w = w ^ 10'd1;
        return w;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_run = 0; m_off = 0; m_loss = 0;
        m_w1 = '0; m_w2 = '0;
        e_lock = 0; e_vde = 0; e_cd = '0; e_vd = '0;
    endtask

    // mode 0 hunts for a token, 1 counts consecutive tokens, 2 is locked
    task automatic model_step(input logic [9:0] w);
        logic [19:0] cat;
        logic [9:0]  win;
        int          t;
        cat = {m_w1, m_w2} >> m_off;
        win = cat[9:0];
        t = tok_idx(win);
        if (m_mode == 0) begin
            if (t >= 0) begin m_mode = 1; m_run = 1; end
            else if (++m_run == SW) begin m_off = (m_off + 1) % 10; m_run = 0; end
        end else if (m_mode == 1) begin
            if (t < 0) begin m_mode = 0; m_off = (m_off + 1) % 10; m_run = 0; end
            else if (++m_run == LC) begin m_mode = 2; m_run = 0; end
        end else begin
            if (t >= 0) m_run = 0;
            else if (++m_run == LW) begin
                m_mode = 0; m_run = 0;
                if (m_loss < 255) m_loss++;
            end
        end
        e_lock = (m_mode == 2);
        if (!e_lock) begin e_vde = 0; e_cd = '0; e_vd = '0; end
        else if (t >= 0) begin e_vde = 0; e_vd = '0; e_cd = 2'(t); end
        else begin e_vde = 1; e_vd = ref_decode(win); end
        m_w2 = m_w1;
        m_w1 = w;
    endtask

    task automatic step(input logic [9:0] w);
        tmds_in = w;
        @(posedge clk);
        #1;
        model_step(w);
        chk("cycle", 32'({locked, offset, loss_cnt, vde, cd, vd}),
            32'({e_lock, 4'(m_off), 8'(m_loss), e_vde, e_cd, e_vd}));
    endtask

    initial begin
        logic [9:0] seq [6];
        logic [9:0] rot;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'({locked, offset, loss_cnt, vde, cd, vd}), 32'd0);
        rst = 1'b0;

        repeat (20) step(tok[0]);
        chk("lock_aligned", 32'(locked), 32'd1);
        chk("offset_aligned", 32'(offset), 32'd0);
        step(10'h100);
        step(10'h200);
        step(tok[0]);
        chk("vde_data", 32'(vde), 32'd1);
        chk("vd_00", 32'(vd), 32'h00);
        step(tok[0]);
        chk("vd_ff", 32'(vd), 32'hFF);

        seq = '{tok[0], tok[1], tok[2], tok[3], tok[0], tok[0]};
        for (int i = 0; i < 6; i++) begin
            step(seq[i]);
            if (i >= 2) begin
                chk("cd_order", 32'(cd), 32'(i - 2));
                chk("vde_token", 32'(vde), 32'd0);
            end
        end

        for (int i = 0; i < 300; i++)
            step((i % 16 == 0 || $urandom_range(0, 3) == 0) ? tok[$urandom_range(0, 3)] : 10'($urandom_range(0, 1023)));

        repeat (66) step(nontok());
        chk("loss_unlocked", 32'(locked), 32'd0);
        chk("loss_count", 32'(loss_cnt), 32'd1);
        chk("loss_outputs", 32'({vde, cd, vd}), 32'd0);
        repeat (20) step(tok[0]);
        chk("relock", 32'(locked), 32'd1);
        chk("relock_offset", 32'(offset), 32'd0);

        rot = {tok[1][6:0], tok[1][9:7]};
        repeat (200) step(rot);
        chk("rot_locked", 32'(locked), 32'd1);
        chk("rot_offset", 32'(offset), 32'd3);
        chk("rot_cd", 32'(cd), 32'd1);
        chk("rot_loss", 32'(loss_cnt), 32'd2);

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_vde", 32'(vde), 32'd0);
        chk("arst_offset", 32'(offset), 32'd0);
        chk("arst_loss", 32'(loss_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        step(tok[0]);
        step(tok[0]);
        repeat (3) step(10'h100);
        chk("false_offset", 32'(offset), 32'd1);
        chk("false_locked", 32'(locked), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/tmds_decoder.md
# tmds_decoder

Receive-side counterpart of the TMDS channel encoder: takes raw 10-bit parallel words from a per-channel deserializer, finds the symbol boundary by bit-slipping until control tokens are seen reliably, and decodes each aligned symbol back into 8-bit video data, 2-bit control data and a video-data-enable flag. One instance sits per colour channel between the deserializer and the HDMI sink's timing recovery logic.

## Interface
- `LOCK_COUNT`, 16: consecutive control tokens at one offset required to declare lock.
- `SEARCH_WAIT`, 4096: cycles without any control token before slipping to the next offset.
- `LOSS_WAIT`, 65536: cycles in LOCKED without any control token before dropping lock.
- `clk`  in  1  pixel clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tmds_in`  in  10  raw deserialized word; bit 0 is the earliest received bit.
- `vd`  out  8  decoded video data.
- `cd`  out  2  decoded control data.
- `vde`  out  1  1 = `vd` valid (data symbol), 0 = `cd` valid (control token).
- `locked`  out  1  symbol alignment established.
- `offset`  out  4  current bit offset, 0..9.
- `loss_cnt`  out  8  saturating count of LOCKED→SEARCH transitions.

## Operation
- Word history: `w1 <= tmds_in`, `w2 <= w1`; window = `{w1,w2}[offset+9 : offset]` (combinational mux).
- Control tokens (CD=00/01/10/11): 10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011. `is_ctl` = window equals any of them.
- Data decode: `d = window[9] ? ~window[7:0] : window[7:0]`; `vd[0]=d[0]`; for i=1..7, `vd[i] = window[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1])`.
- Output register: if `is_ctl`: `vde=0`, `cd`=token value, `vd=0`. Else `vde=1`, `vd`=decoded, `cd` holds previous value. When not LOCKED: `vde=0`, `cd=0`, `vd=0`.
- FSM states SEARCH, CONFIRM, LOCKED; one counter `cnt` (width `$clog2(LOSS_WAIT)+1`) reused per state.
  - SEARCH: `is_ctl` → CONFIRM, `cnt=1`. Else `cnt++`; at `cnt==SEARCH_WAIT-1`: `offset = (offset==9) ? 0 : offset+1`, `cnt=0`.
  - CONFIRM: `is_ctl` → `cnt++`; at `cnt==LOCK_COUNT-1` plus token → LOCKED, `cnt=0`. Non-token → SEARCH, offset increments (wrap 9→0), `cnt=0`.
  - LOCKED: `is_ctl` → `cnt=0`. Else `cnt++`; at `cnt==LOSS_WAIT-1` → SEARCH, `cnt=0`, `loss_cnt++` (saturates at 255), offset unchanged.
- A video period ending (data → token) inside LOCKED never affects lock.

## Timing
- Reset values: all registers 0; state SEARCH; `offset=0`, `locked=0`, `vd=0`, `cd=0`, `vde=0`, `loss_cnt=0`.
- Latency at `offset=0`: word on `tmds_in` at edge k appears on `vd/cd/vde` after edge k+2. At offsets 1..9 the symbol straddles `w1/w2`, so latency is the same counting from its last bit's word.
- `locked` is registered, rising on the same edge as the first decoded output. The entering-LOCKED token is itself output.
- Offset change takes effect on the window in the cycle after the slip edge. Output is suppressed until relock.
- Reset mid-operation clears everything immediately (asynchronous). Deassertion is synchronised upstream.
- Parameters are tested with small values: `SEARCH_WAIT=32`, `LOSS_WAIT=64`, `LOCK_COUNT=4`.

## Structure
- Shared package `tmds_pkg`: the four control-token constants (also used by the encoder) and the FSM state enum.
- Sub-module `tmds_symbol_decode`: combinational 10-bit → {is_ctl, vde, cd, vd}. The top holds the history, offset mux, FSM, counters and output register.

## Test plan
- Aligned blanking: 20× 10'b1101010100 then 10'h100, 10'h200 → `locked=1` after the 4th token (LOCK_COUNT=4), `offset=0`; then `vde=1`, `vd=8'h00`, then `vd=8'hFF`.
- All four tokens after lock → `vde=0`, `cd`=00, 01, 10, 11 in order, 2 cycles after input.
- Stream rotated by 3 bits: repeated token 10'b0010101011 → `offset` steps every 32 cycles, locks at `offset=3`, `cd=2'b01`.
- False match: 2 tokens then a data word during CONFIRM → returns to SEARCH, `offset` increments, `locked` stays 0.
- Loss: after lock, 64 consecutive data words without a token → `locked=0`, `loss_cnt=1`, outputs forced to 0. Reapplying tokens relocks at the same offset.
- Assert `rst` while LOCKED → `locked`, `vde`, `offset`, `loss_cnt` are 0 immediately, without waiting for a clock edge.
